// File: rtl/snake_step_ctrl.sv
// Snake head step controller: paces direction buttons into one-cycle
// step/load commands for the X/Y parallel-load up/down position counters.
module snake_step_ctrl #(
    parameter int         WIDTH     = 8,
    parameter int         GRID_W    = 16,
    parameter int         GRID_H    = 12,
    parameter int         TICK_DIV  = 4,
    parameter logic [1:0] START_DIR = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic [WIDTH-1:0] x_pos,
    input  logic [WIDTH-1:0] y_pos,
    output logic             x_step,
    output logic             x_sel,
    output logic             x_down,
    output logic [WIDTH-1:0] x_in,
    output logic             y_step,
    output logic             y_sel,
    output logic             y_down,
    output logic [WIDTH-1:0] y_in,
    output logic [1:0]       dir,
    output logic             running
);

    localparam int               DIV_W   = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] X_LAST  = WIDTH'(GRID_W - 1);
    localparam logic [WIDTH-1:0] X_SIZE  = WIDTH'(GRID_W);
    localparam logic [WIDTH-1:0] Y_LAST  = WIDTH'(GRID_H - 1);
    localparam logic [WIDTH-1:0] Y_SIZE  = WIDTH'(GRID_H);

    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_UP    = 2'd2;
    localparam logic [1:0] D_DOWN  = 2'd3;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_dir, r_pend;
    logic             r_x_step, r_x_sel, r_x_down;
    logic             r_y_step, r_y_sel, r_y_down;
    logic [WIDTH-1:0] r_x_in, r_y_in;

    logic             w_tick, w_btn_vld, w_rev;
    logic [1:0]       w_btn_dir, w_pend_nxt;
    logic             w_x_axis, w_x_load, w_y_load;
    logic [WIDTH-1:0] w_x_ld_val, w_y_ld_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (run_en)  w_state_nxt = S_RUN;
            S_RUN:   if (!run_en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_tick = (r_state == S_RUN) && run_en && (r_div == DIV_MAX);

    // Fixed priority up > down > left > right.
    assign w_btn_vld = btn_up | btn_down | btn_left | btn_right;
    assign w_btn_dir = btn_up ? D_UP : btn_down ? D_DOWN : btn_left ? D_LEFT : D_RIGHT;
    // Opposite directions differ only in bit 0 with this encoding.
    assign w_rev      = ((w_btn_dir ^ r_dir) == 2'b01);
    assign w_pend_nxt = (w_btn_vld && !w_rev) ? w_btn_dir : r_pend;

    assign w_x_axis   = ~r_pend[1];
    assign w_x_load   = (r_pend == D_RIGHT) ? (x_pos >= X_LAST)
                                            : ((x_pos == '0) || (x_pos >= X_SIZE));
    assign w_x_ld_val = (r_pend == D_RIGHT) ? '0 : X_LAST;
    assign w_y_load   = (r_pend == D_DOWN) ? (y_pos >= Y_LAST)
                                           : ((y_pos == '0) || (y_pos >= Y_SIZE));
    assign w_y_ld_val = (r_pend == D_DOWN) ? '0 : Y_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div    <= '0;
            r_dir    <= START_DIR;
            r_pend   <= START_DIR;
            r_x_step <= 1'b0;
            r_x_sel  <= 1'b0;
            r_x_down <= 1'b0;
            r_x_in   <= '0;
            r_y_step <= 1'b0;
            r_y_sel  <= 1'b0;
            r_y_down <= 1'b0;
            r_y_in   <= '0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_x_step <= 1'b0;
            r_x_sel  <= 1'b0;
            r_x_down <= 1'b0;
            r_y_step <= 1'b0;
            r_y_sel  <= 1'b0;
            r_y_down <= 1'b0;
            if (r_state == S_RUN && w_state_nxt == S_RUN)
                r_div <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
            else
                r_div <= '0;
            if (w_tick) begin
                r_dir <= r_pend;
                if (w_x_axis) begin
                    r_x_step <= 1'b1;
                    r_x_sel  <= w_x_load;
                    r_x_down <= ~w_x_load & r_pend[0];
                    if (w_x_load) r_x_in <= w_x_ld_val;
                end else begin
                    r_y_step <= 1'b1;
                    r_y_sel  <= w_y_load;
                    r_y_down <= ~w_y_load & ~r_pend[0];
                    if (w_y_load) r_y_in <= w_y_ld_val;
                end
            end
        end
    end

    assign x_step  = r_x_step;
    assign x_sel   = r_x_sel;
    assign x_down  = r_x_down;
    assign x_in    = r_x_in;
    assign y_step  = r_y_step;
    assign y_sel   = r_y_sel;
    assign y_down  = r_y_down;
    assign y_in    = r_y_in;
    assign dir     = r_dir;
    assign running = (r_state == S_RUN);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Scoreboard bench for snake_step_ctrl: stimulus queues hand-computed step
// commands with their due cycle; a monitor pops one per observed strobe.
module tb_snake_step_ctrl;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset, run_en, btn_up, btn_down, btn_left, btn_right;
    logic [7:0] x_pos, y_pos;
    logic       x_step, x_sel, x_down, y_step, y_sel, y_down, running;
    logic [7:0] x_in, y_in;
    logic [1:0] dir;

    typedef struct {
        int         cyc;
        logic       xs, xl, xd;
        logic [7:0] xi;
        logic       ys, yl, yd;
        logic [7:0] yi;
        logic [1:0] d;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0, vecs = 0, errs = 0, nxt = 0, c = 0;
    logic [7:0] ex_xin = 8'd0, ex_yin = 8'd0;

    snake_step_ctrl #(.WIDTH(8), .GRID_W(16), .GRID_H(12), .TICK_DIV(TD), .START_DIR(2'd0)) dut (
        .clk(clk), .reset(reset), .run_en(run_en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .x_pos(x_pos), .y_pos(y_pos),
        .x_step(x_step), .x_sel(x_sel), .x_down(x_down), .x_in(x_in),
        .y_step(y_step), .y_sel(y_sel), .y_down(y_down), .y_in(y_in),
        .dir(dir), .running(running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        tick(1);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_x(input logic ld, input logic dn, input logic [7:0] v, input logic [1:0] d);
        exp_t e;
        if (ld) ex_xin = v;
        e.cyc = nxt; e.xs = 1; e.xl = ld; e.xd = dn; e.xi = ex_xin;
        e.ys = 0; e.yl = 0; e.yd = 0; e.yi = ex_yin; e.d = d;
        q.push_back(e);
        nxt += TD;
    endtask

    task automatic push_y(input logic ld, input logic dn, input logic [7:0] v, input logic [1:0] d);
        exp_t e;
        if (ld) ex_yin = v;
        e.cyc = nxt; e.ys = 1; e.yl = ld; e.yd = dn; e.yi = ex_yin;
        e.xs = 0; e.xl = 0; e.xd = 0; e.xi = ex_xin; e.d = d;
        q.push_back(e);
        nxt += TD;
    endtask

    initial begin
        reset = 1; run_en = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        x_pos = 8'd5; y_pos = 8'd3;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    while (q.size() > 0 && q[0].cyc < cyc) begin
                        e = q.pop_front();
                        vecs++; errs++;
                        $display("FAIL missed_strobe: got no strobe by cyc %0d, want one at cyc %0d", cyc, e.cyc);
                    end
                    if (!reset && (x_step || y_step)) begin
                        vecs++;
                        if (q.size() == 0) begin
                            errs++;
                            $display("FAIL unexpected_strobe: got x_step=%b y_step=%b at cyc %0d, want none",
                                     x_step, y_step, cyc);
                        end else begin
                            e = q.pop_front();
                            if (e.cyc != cyc || e.xs !== x_step || e.xl !== x_sel || e.xd !== x_down ||
                                e.xi !== x_in || e.ys !== y_step || e.yl !== y_sel || e.yd !== y_down ||
                                e.yi !== y_in || e.d !== dir) begin
                                errs++;
                                $display("FAIL strobe: got cyc%0d x(s%b l%b d%b in%0d) y(s%b l%b d%b in%0d) dir%0d, want cyc%0d x(s%b l%b d%b in%0d) y(s%b l%b d%b in%0d) dir%0d",
                                         cyc, x_step, x_sel, x_down, x_in, y_step, y_sel, y_down, y_in, dir,
                                         e.cyc, e.xs, e.xl, e.xd, e.xi, e.ys, e.yl, e.yd, e.yi, e.d);
                            end
                        end
                    end
                end
            end
            begin : stimulus
                tick(2);
                chk("rst_dir", dir, 0);
                chk("rst_running", running, 0);
                chk("rst_x_step", x_step, 0);
                chk("rst_y_step", y_step, 0);
                chk("rst_x_in", x_in, 0);
                reset = 0;
                tick(2);

                // Free run right, first strobe TD cycles after RUN is entered.
                c = cyc; run_en = 1; nxt = c + 1 + TD;
                push_x(0, 0, 0, 2'd0); push_x(0, 0, 0, 2'd0); push_x(0, 0, 0, 2'd0);
                wait_until(c + 2);
                chk("running", running, 1);
                chk("dir_start", dir, 0);

                wait_until(c + 13);
                push_y(0, 1, 0, 2'd2); push_y(0, 1, 0, 2'd2);
                press(1, 0, 0, 0);

                wait_until(c + 21);
                push_x(0, 0, 0, 2'd0);
                press(0, 0, 0, 1);

                // Left against committed right is a reversal: dropped.
                wait_until(c + 25);
                push_x(0, 0, 0, 2'd0);
                press(0, 0, 1, 0);

                // Up then left in one period: left still reverses committed right.
                wait_until(c + 29);
                push_y(0, 1, 0, 2'd2);
                press(1, 0, 0, 0);
                wait_until(c + 31);
                press(0, 0, 1, 0);

                wait_until(c + 33);
                x_pos = 8'd15;
                push_x(1, 0, 8'd0, 2'd0);
                press(0, 0, 0, 1);

                wait_until(c + 37);
                push_y(0, 1, 0, 2'd2);
                press(1, 0, 0, 0);

                wait_until(c + 41);
                x_pos = 8'd0;
                push_x(1, 0, 8'd15, 2'd1);
                press(0, 0, 1, 0);

                wait_until(c + 45);
                x_pos = 8'd20;
                push_x(1, 0, 8'd15, 2'd1);

                wait_until(c + 49);
                y_pos = 8'd11;
                push_y(1, 0, 8'd0, 2'd3);
                press(0, 1, 0, 0);

                wait_until(c + 53);
                x_pos = 8'd5;
                push_x(0, 0, 0, 2'd0);
                press(0, 0, 0, 1);

                wait_until(c + 57);
                y_pos = 8'd0;
                push_y(1, 0, 8'd11, 2'd2);
                press(1, 0, 0, 1);

                // Press sampled on the strobe edge applies to the following step.
                wait_until(c + 64);
                y_pos = 8'd5;
                push_y(0, 1, 0, 2'd2); push_x(0, 0, 0, 2'd0);
                press(0, 0, 0, 1);

                wait_until(c + 69);
                run_en = 0;
                wait_until(c + 71);
                chk("paused_running", running, 0);
                wait_until(c + 72);
                run_en = 1; nxt = cyc + 1 + TD;
                push_x(0, 0, 0, 2'd0);

                wait_until(c + 77);
                press(1, 0, 0, 0);
                wait_until(c + 81);
                chk("pre_rst_y_step", y_step, 1);
                #2 reset = 1;
                #1;
                chk("async_rst_y_step", y_step, 0);
                chk("async_rst_dir", dir, 0);
                chk("async_rst_running", running, 0);
                chk("async_rst_x_in", x_in, 0);
                chk("async_rst_y_in", y_in, 0);
                run_en = 0;
                tick(3);
                reset = 0;
                tick(6);
                chk("idle_after_rst", running, 0);
                chk("queue_empty", q.size(), 0);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
